// File: rtl/block_sf_pkg.sv
// Shared types and default sizes for the sum/difference scale-factor block.
package block_sf_pkg;

  localparam int W_DEF  = 18;
  localparam int KW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC_S = 2'd1,
    ST_CALC_D = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/sf_shift_add.sv
// Serial shift-add multiplier (one multiplier bit per step) with the
// round-half-up and saturate/wrap stage folded onto the final accumulator.
module sf_shift_add
  import block_sf_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int KW = KW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic signed [W:0]    op_i,
  input  logic        [KW-1:0] k_i,
  input  logic                 rnd_i,
  input  logic                 sat_i,
  output logic signed [W-1:0]  res_o
);

  localparam int PW = W + KW + 1;
  localparam logic signed [PW-1:0] RND_C = {{(PW-1){1'b0}}, 1'b1} << (KW-1);
  localparam logic signed [PW-1:0] MAX_V = {{(KW+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(KW+2){1'b1}}, {(W-1){1'b0}}};

  logic signed [PW-1:0] mcand_q;
  logic signed [PW-1:0] acc_q;
  logic signed [PW-1:0] acc_d;
  logic signed [PW-1:0] shifted;
  logic        [KW-1:0] mplier_q;

  // The rounding constant is preloaded into the accumulator, so the single
  // adder below covers both the partial products and the round term.
  always_comb begin
    acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    shifted = acc_d >>> KW;
    res_o   = shifted[W-1:0];
    if (sat_i) begin
      if (shifted > MAX_V)      res_o = MAX_V[W-1:0];
      else if (shifted < MIN_V) res_o = MIN_V[W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (load_i) begin
      mcand_q  <= {{KW{op_i[W]}}, op_i};
      acc_q    <= rnd_i ? RND_C : '0;
      mplier_q <= k_i;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q <<< 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/block_sf_param.sv
// Scales L+R by Ks/2^KW and L-R by Kd/2^KW through one shared serial multiplier.
//   state     | meaning
//   ST_IDLE   | in_ready high, waiting for in_valid
//   ST_CALC_S | KW shift-add steps on L+R; LpR registered on the last step
//   ST_CALC_D | KW shift-add steps on L-R; LmR registered on the last step
//   ST_DONE   | one turnaround cycle before accepting the next sample
module block_sf_param
  import block_sf_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int KW = KW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  LEFT,
  input  logic signed [W-1:0]  RIGHT,
  input  logic        [KW-1:0] Ks,
  input  logic        [KW-1:0] Kd,
  input  logic                 round_en,
  input  logic                 sat_en,
  output logic signed [W-1:0]  LI_in_LpR,
  output logic signed [W-1:0]  LI_in_LmR,
  output logic                 ready_out_LpR,
  output logic                 ready_out_LmR
);

  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic signed [W:0]    d_q;
  logic [KW-1:0]        kd_q;
  logic                 rnd_q;
  logic                 sat_q;
  logic                 rdy_q;
  logic                 stb_s_q;
  logic                 stb_d_q;
  logic signed [W-1:0]  lpr_q;
  logic signed [W-1:0]  lmr_q;

  logic                 accept;
  logic                 cnt_tc;
  logic                 mul_load;
  logic                 mul_step;
  logic signed [W:0]    sum_w;
  logic signed [W:0]    diff_w;
  logic signed [W:0]    mul_op;
  logic [KW-1:0]        mul_k;
  logic                 mul_rnd;
  logic signed [W-1:0]  mul_res;

  // The difference operand is parked in d_q at acceptance and loaded into
  // the multiplier on the same edge that retires the sum pass.
  always_comb begin
    sum_w    = {LEFT[W-1], LEFT} + {RIGHT[W-1], RIGHT};
    diff_w   = {LEFT[W-1], LEFT} - {RIGHT[W-1], RIGHT};
    accept   = (state_q == ST_IDLE) && rdy_q && in_valid;
    cnt_tc   = (cnt_q == '0);
    mul_step = (state_q == ST_CALC_S) || (state_q == ST_CALC_D);
    mul_load = accept || ((state_q == ST_CALC_S) && cnt_tc);
    mul_op   = accept ? sum_w : d_q;
    mul_k    = accept ? Ks : kd_q;
    mul_rnd  = accept ? round_en : rnd_q;
  end

  sf_shift_add #(.W(W), .KW(KW)) u_mul (
    .clock  (clock),
    .reset  (reset),
    .load_i (mul_load),
    .step_i (mul_step),
    .op_i   (mul_op),
    .k_i    (mul_k),
    .rnd_i  (mul_rnd),
    .sat_i  (sat_q),
    .res_o  (mul_res)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      kd_q    <= '0;
      rnd_q   <= 1'b0;
      sat_q   <= 1'b0;
      rdy_q   <= 1'b0;
      stb_s_q <= 1'b0;
      stb_d_q <= 1'b0;
      lpr_q   <= '0;
      lmr_q   <= '0;
    end else begin
      stb_s_q <= 1'b0;
      stb_d_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rdy_q <= !accept;
          if (accept) begin
            state_q <= ST_CALC_S;
            cnt_q   <= CW'(KW-1);
            d_q     <= diff_w;
            kd_q    <= Kd;
            rnd_q   <= round_en;
            sat_q   <= sat_en;
          end
        end
        ST_CALC_S: begin
          if (cnt_tc) begin
            state_q <= ST_CALC_D;
            cnt_q   <= CW'(KW-1);
            lpr_q   <= mul_res;
            stb_s_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_CALC_D: begin
          if (cnt_tc) begin
            state_q <= ST_DONE;
            lmr_q   <= mul_res;
            stb_d_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = rdy_q;
  assign LI_in_LpR     = lpr_q;
  assign LI_in_LmR     = lmr_q;
  assign ready_out_LpR = stb_s_q;
  assign ready_out_LmR = stb_d_q;

endmodule

// File: tb/tb_block_sf_param.sv
// Directed bench for block_sf_param: cycle-level reference model plus literal checks.
module tb_block_sf_param;

  localparam int W  = 18;
  localparam int KW = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 round_en = 1'b0;
  logic                 sat_en = 1'b0;
  logic signed [W-1:0]  LEFT = '0;
  logic signed [W-1:0]  RIGHT = '0;
  logic        [KW-1:0] Ks = '0;
  logic        [KW-1:0] Kd = '0;
  logic                 in_ready;
  logic signed [W-1:0]  LI_in_LpR;
  logic signed [W-1:0]  LI_in_LmR;
  logic                 ready_out_LpR;
  logic                 ready_out_LmR;

  block_sf_param #(.W(W), .KW(KW)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .LEFT          (LEFT),
    .RIGHT         (RIGHT),
    .Ks            (Ks),
    .Kd            (Kd),
    .round_en      (round_en),
    .sat_en        (sat_en),
    .LI_in_LpR     (LI_in_LpR),
    .LI_in_LmR     (LI_in_LmR),
    .ready_out_LpR (ready_out_LpR),
    .ready_out_LmR (ready_out_LmR)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference arithmetic: exact product, optional +half LSB, floor shift, clamp or wrap.
  function automatic longint model_res(longint s, longint k, bit rnd, bit sat);
    longint p, r, hi, lo, span;
    hi   = (longint'(1) <<< (W-1)) - 1;
    lo   = -(longint'(1) <<< (W-1));
    span = longint'(1) <<< W;
    p = s * k;
    if (rnd) p = p + (longint'(1) <<< (KW-1));
    r = p >>> KW;
    if (sat) begin
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
    end else begin
      r = r & (span - 1);
      if (r > hi) r = r - span;
    end
    return r;
  endfunction

  // Timing model: result for L+R appears KW edges after acceptance, L-R at 2KW,
  // next acceptance possible 2KW+2 edges later.
  longint m_lpr = 0, m_lmr = 0, p_lp = 0, p_lm = 0;
  bit     m_rdy = 0, m_slp = 0, m_slm = 0, chk_on = 0;
  int     lp_t = 0, lm_t = 0, busy = 0;

  always @(posedge clock) begin
    chk_on = 1;
    m_slp  = 0;
    m_slm  = 0;
    if (reset) begin
      m_rdy = 0; m_lpr = 0; m_lmr = 0; lp_t = 0; lm_t = 0; busy = 0;
    end else begin
      if (lp_t > 0) begin
        lp_t--;
        if (lp_t == 0) begin m_lpr = p_lp; m_slp = 1; end
      end
      if (lm_t > 0) begin
        lm_t--;
        if (lm_t == 0) begin m_lmr = p_lm; m_slm = 1; end
      end
      if (m_rdy && in_valid) begin
        p_lp  = model_res(longint'(LEFT) + longint'(RIGHT), longint'(Ks), round_en, sat_en);
        p_lm  = model_res(longint'(LEFT) - longint'(RIGHT), longint'(Kd), round_en, sat_en);
        lp_t  = KW;
        lm_t  = 2*KW;
        busy  = 2*KW + 1;
        m_rdy = 0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) m_rdy = 1;
      end else begin
        m_rdy = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      check("cyc_in_ready", longint'(in_ready), longint'(m_rdy));
      check("cyc_stb_lpr", longint'(ready_out_LpR), longint'(m_slp));
      check("cyc_stb_lmr", longint'(ready_out_LmR), longint'(m_slm));
      check("cyc_lpr", longint'(LI_in_LpR), m_lpr);
      check("cyc_lmr", longint'(LI_in_LmR), m_lmr);
      check("cyc_stb_excl", longint'(ready_out_LpR & ready_out_LmR), 0);
    end
  end

  task automatic wait_ready(string nm);
    for (int i = 0; i < 30 && in_ready !== 1'b1; i++) @(negedge clock);
    check({nm, "_ready"}, longint'(in_ready), 1);
  endtask

  task automatic run_vec(string nm, longint l, longint r, longint ks, longint kd,
                         bit rnd, bit sat, longint e_lp, longint e_lm);
    int     lp_n = -1, lm_n = -1;
    longint lp_v = 0, lm_v = 0;
    wait_ready(nm);
    LEFT = W'(l); RIGHT = W'(r); Ks = KW'(ks); Kd = KW'(kd);
    round_en = rnd; sat_en = sat; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    LEFT = W'($urandom); RIGHT = W'($urandom); Ks = KW'($urandom); Kd = KW'($urandom);
    round_en = ~rnd; sat_en = ~sat;
    for (int n = 1; n <= 2*KW + 3; n++) begin
      @(negedge clock);
      if (ready_out_LpR) begin lp_n = n; lp_v = longint'(LI_in_LpR); end
      if (ready_out_LmR) begin lm_n = n; lm_v = longint'(LI_in_LmR); end
    end
    check({nm, "_lpr_lat"}, lp_n, KW);
    check({nm, "_lmr_lat"}, lm_n, 2*KW);
    check({nm, "_lpr"}, lp_v, e_lp);
    check({nm, "_lmr"}, lm_v, e_lm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_i[$];
    int lows[$];
    int low_cnt;
    int stb_cnt;

    repeat (3) @(negedge clock);
    check("rst_ready", longint'(in_ready), 0);
    check("rst_lpr", longint'(LI_in_LpR), 0);
    check("rst_stb", longint'(ready_out_LpR | ready_out_LmR), 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", longint'(in_ready), 1);

    run_vec("floor",     15,      32,     8, 12, 0, 1,  23,     -13);
    run_vec("round",     15,      32,     8, 12, 1, 1,  24,     -13);
    run_vec("sat_pos",   131071,  131071, 15, 0, 0, 1,  131071, 0);
    run_vec("wrap_pos",  131071,  131071, 15, 0, 0, 0,  -16386, 0);
    run_vec("sat_neg",   -131072, 131071, 15, 15, 0, 1, -1,     -131072);
    run_vec("k_zero",    1000,    -77,    0,  0, 1, 1,  0,      0);
    run_vec("wrap_neg",  -131072, -131072, 15, 1, 0, 0, 16384,  0);

    // Back-to-back offers: acceptances every 2KW+2 cycles.
    wait_ready("tp");
    LEFT = 15; RIGHT = 32; Ks = 8; Kd = 12; round_en = 0; sat_en = 1; in_valid = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (in_ready) begin
        acc_i.push_back(i);
        lows.push_back(low_cnt);
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("tp_count", acc_i.size(), 4);
    for (int j = 1; j < acc_i.size(); j++) begin
      check("tp_gap", acc_i[j] - acc_i[j-1], 2*KW + 2);
      check("tp_busy", lows[j], 2*KW + 1);
    end
    repeat (12) @(negedge clock);

    // Reset three cycles into a computation.
    wait_ready("mid_rst");
    LEFT = 15; RIGHT = 32; Ks = 8; Kd = 12; round_en = 0; sat_en = 1; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_ready_low", longint'(in_ready), 0);
    @(negedge clock);
    check("mid_rst_ready_high", longint'(in_ready), 1);
    stb_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (ready_out_LpR || ready_out_LmR) stb_cnt++;
      @(negedge clock);
    end
    check("mid_rst_no_stb", stb_cnt, 0);
    check("mid_rst_lpr", longint'(LI_in_LpR), 0);
    check("mid_rst_lmr", longint'(LI_in_LmR), 0);

    run_vec("after_rst", 15, 32, 8, 12, 0, 1, 23, -13);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/block_sf_param.md
BLOCK_SF_PARAM -- requirements
Module: block_sf_param

Interface
REQ-001 SHALL have parameter W, default 18: LEFT/RIGHT/output sample width, legal range 8..32.
REQ-002 SHALL have parameter KW, default 4: scale-factor width, legal range 1..8.
REQ-003 SHALL have port clock, input, 1 bit: single clock, all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a new LEFT/RIGHT/Ks/Kd set is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-007 SHALL have ports LEFT and RIGHT, input, W bits each, signed: audio channels.
REQ-008 SHALL have ports Ks and Kd, input, KW bits each, unsigned: sum/difference scale factors, each interpreted as K/2^KW.
REQ-009 SHALL have port round_en, input, 1 bit: 1 = round half up, 0 = floor, i.e. the withoutround behaviour.
REQ-010 SHALL have port sat_en, input, 1 bit: 1 = saturate to W bits, 0 = two's-complement wrap.
REQ-011 SHALL have ports LI_in_LpR and LI_in_LmR, output, W bits each, signed: scaled L+R and L-R.
REQ-012 SHALL have ports ready_out_LpR and ready_out_LmR, output, 1 bit each: one-cycle result strobes.

Function
REQ-013 SHALL accept a sample on the rising edge where in_valid && in_ready, capturing LEFT, RIGHT, Ks, Kd, round_en and sat_en; call this edge cycle T.
REQ-014 SHALL ignore in_valid whenever in_ready=0, with no capture and no side effect.
REQ-015 SHALL form the sum S=LEFT+RIGHT and the difference D=LEFT-RIGHT at W+1 bits, signed, with no overflow.
REQ-016 SHALL compute P=S*Ks, then Q=D*Kd, by a serial shift-add over KW cycles each, using one shared adder datapath.
REQ-017 SHALL compute result = (P + (round_en ? 2^(KW-1) : 0)) >>> KW, an arithmetic shift.
REQ-018 With sat_en=1, SHALL clamp results above 2^(W-1)-1 to that value and results below -2^(W-1) to -2^(W-1).
REQ-019 With sat_en=0, SHALL output the low W bits of the result.
REQ-020 SHALL sequence an FSM IDLE -> CALC_S (KW cycles) -> CALC_D (KW cycles) -> DONE (1 cycle) -> IDLE.
REQ-021 SHALL update LI_in_LpR and pulse ready_out_LpR for exactly one cycle at T+KW+1.
REQ-022 SHALL update LI_in_LmR and pulse ready_out_LmR for exactly one cycle at T+2KW+1.
REQ-023 SHALL enter DONE at T+2KW+1 and assert in_ready at T+2KW+2, giving throughput of one sample per 2KW+2 cycles.
REQ-024 SHALL hold LI_in_LpR and LI_in_LmR between strobes; the two strobes SHALL never be high together.
REQ-025 With Ks=0 or Kd=0, SHALL still take the full latency and output 0 (round_en=1 also gives 0).
REQ-026 Changes on LEFT, RIGHT, Ks, Kd, round_en or sat_en after cycle T SHALL NOT affect the results in flight.

Reset
REQ-027 While reset=1, SHALL force the state to IDLE, LI_in_LpR=0, LI_in_LmR=0, ready_out_LpR=0, ready_out_LmR=0 and clear all datapath registers.
REQ-028 SHALL hold in_ready at 0 while reset=1 and drive it to 1 on the first cycle after reset deasserts.
REQ-029 A reset asserted mid-operation SHALL abort the sample: no pending strobe is issued, and outputs read 0.

Structure
REQ-030 SHALL place the FSM state encodings (IDLE, CALC_S, CALC_D, DONE) and the default W/KW constants in shared package block_sf_pkg.
REQ-031 SHALL place the serial shift-add multiplier with round/saturate stage in one sub-module, sf_shift_add, instantiated once and reused for the S and D passes.

Verification
REQ-032 W=18, KW=4: LEFT=15, RIGHT=32, Ks=8, Kd=12, round_en=0, sat_en=1 -> LpR=23 at T+5, LmR=-13 at T+9.
REQ-033 Same stimulus as REQ-032 with round_en=1 -> LpR=24, LmR=-13.
REQ-034 LEFT=RIGHT=131071, Ks=15, Kd=0 -> with sat_en=1, LpR=131071 and LmR=0; with sat_en=0, LpR=-16386.
REQ-035 LEFT=-131072, RIGHT=131071, Kd=15, sat_en=1 -> LmR=-131072.
REQ-036 Hold in_valid=1 continuously -> acceptances exactly 10 cycles apart, and in_ready low during the 9 busy cycles (CALC_S, CALC_D, DONE).
REQ-037 Assert reset at T+3 -> no strobes follow, outputs read 0, in_ready=1 on the cycle after reset deasserts; a fresh sample then completes with correct results.
